// File: rtl/schedule_1_pkg.sv
// Shared types and constants for the schedule_1 issue scheduler.
// Lane field widths, the registered output record and the bubble value.
package schedule_1_pkg;

  localparam int PC_W         = 32;
  localparam int OPC_W        = 17;
  localparam int REG_W        = 5;
  localparam int CSR_W        = 12;
  localparam int IMM_W        = 32;
  localparam int SCHED_LANE_W = 4;
  localparam int NREGS        = 32;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [CSR_W-1:0] csr;
    logic [IMM_W-1:0] imm;
  } lane_fields_t;

  typedef struct packed {
    logic                    valid;
    logic [SCHED_LANE_W-1:0] lane;
    lane_fields_t            f;
  } sched_out_t;

  localparam sched_out_t SCHED_BUBBLE = '0;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] idx);
    logic [NREGS-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/sched_scoreboard.sv
// Register busy scoreboard: one bit per architectural register, x0 never busy.
// Queries see the same-cycle writeback clear; a same-index set beats the clear.
module sched_scoreboard
  import schedule_1_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear_all,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  input  logic [REG_W-1:0] q_idx0,
  input  logic [REG_W-1:0] q_idx1,
  input  logic [REG_W-1:0] q_idx2,
  output logic             q_busy0,
  output logic             q_busy1,
  output logic             q_busy2
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] busy_byp;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (clr_en) clr_mask = reg_onehot(clr_idx);
    if (set_en && (set_idx != '0)) set_mask = reg_onehot(set_idx);
    busy_byp = busy_q & ~clr_mask;
  end

  always_comb begin
    q_busy0 = (q_idx0 != '0) && busy_byp[q_idx0];
    q_busy1 = (q_idx1 != '0) && busy_byp[q_idx1];
    q_busy2 = (q_idx2 != '0) && busy_byp[q_idx2];
  end

  always_ff @(posedge CLK) begin
    if (RST || clear_all) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_byp | set_mask) & ~{{(NREGS-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/schedule_1.sv
// First-stage issue scheduler: picks the highest-index accepting lane, checks
// its operands against the busy scoreboard, then issues or stalls.
module schedule_1
  import schedule_1_pkg::*;
#(
  parameter int COP_NUMS = 1,
  parameter int PNUMS    = COP_NUMS + 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    FLUSH,
  input  logic                    MMU_WAIT,
  input  logic [PNUMS-1:0]        CHECK_ACCEPT,
  input  logic [PC_W*PNUMS-1:0]   CHECK_PC,
  input  logic [OPC_W*PNUMS-1:0]  CHECK_OPCODE,
  input  logic [REG_W*PNUMS-1:0]  CHECK_RD,
  input  logic [REG_W*PNUMS-1:0]  CHECK_RS1,
  input  logic [REG_W*PNUMS-1:0]  CHECK_RS2,
  input  logic [CSR_W*PNUMS-1:0]  CHECK_CSR,
  input  logic [IMM_W*PNUMS-1:0]  CHECK_IMM,
  input  logic                    WB_VALID,
  input  logic [REG_W-1:0]        WB_RD,
  output logic                    STALL,
  output logic                    SCHEDULE_VALID,
  output logic [SCHED_LANE_W-1:0] SCHEDULE_LANE,
  output logic [PC_W-1:0]         SCHEDULE_PC,
  output logic [OPC_W-1:0]        SCHEDULE_OPCODE,
  output logic [REG_W-1:0]        SCHEDULE_RD,
  output logic [REG_W-1:0]        SCHEDULE_RS1,
  output logic [REG_W-1:0]        SCHEDULE_RS2,
  output logic [CSR_W-1:0]        SCHEDULE_CSR,
  output logic [IMM_W-1:0]        SCHEDULE_IMM,
  output logic [31:0]             HAZARD_CNT
);

  lane_fields_t            lane_f [PNUMS];
  lane_fields_t            sel_f;
  logic                    sel_valid;
  logic [SCHED_LANE_W-1:0] sel_idx;
  logic                    busy_rs1;
  logic                    busy_rs2;
  logic                    busy_rd;
  logic                    hazard;
  logic                    issue;
  sched_out_t              out_q;
  logic [31:0]             hcnt_q;

  always_comb begin
    for (int i = 0; i < PNUMS; i++) begin
      lane_f[i].pc     = CHECK_PC[i*PC_W +: PC_W];
      lane_f[i].opcode = CHECK_OPCODE[i*OPC_W +: OPC_W];
      lane_f[i].rd     = CHECK_RD[i*REG_W +: REG_W];
      lane_f[i].rs1    = CHECK_RS1[i*REG_W +: REG_W];
      lane_f[i].rs2    = CHECK_RS2[i*REG_W +: REG_W];
      lane_f[i].csr    = CHECK_CSR[i*CSR_W +: CSR_W];
      lane_f[i].imm    = CHECK_IMM[i*IMM_W +: IMM_W];
    end
  end

  // Ascending scan so the highest accepting lane (a coprocessor) wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_f     = '0;
    for (int i = 0; i < PNUMS; i++) begin
      if (CHECK_ACCEPT[i]) begin
        sel_valid = 1'b1;
        sel_idx   = SCHED_LANE_W'(i);
        sel_f     = lane_f[i];
      end
    end
  end

  sched_scoreboard u_sb (
    .CLK       (CLK),
    .RST       (RST),
    .clear_all (FLUSH),
    .set_en    (issue),
    .set_idx   (sel_f.rd),
    .clr_en    (WB_VALID),
    .clr_idx   (WB_RD),
    .q_idx0    (sel_f.rs1),
    .q_idx1    (sel_f.rs2),
    .q_idx2    (sel_f.rd),
    .q_busy0   (busy_rs1),
    .q_busy1   (busy_rs2),
    .q_busy2   (busy_rd)
  );

  always_comb begin
    hazard = sel_valid && (busy_rs1 || busy_rs2 || busy_rd);
    issue  = sel_valid && !hazard && !MMU_WAIT && !FLUSH && !RST;
    // Frozen pipeline needs no hold request.
    STALL  = hazard && !MMU_WAIT;
  end

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      out_q <= SCHED_BUBBLE;
    end else if (!MMU_WAIT) begin
      if (issue) out_q <= sched_out_t'{valid: 1'b1, lane: sel_idx, f: sel_f};
      else       out_q <= SCHED_BUBBLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hcnt_q <= '0;
    end else if (!FLUSH && !MMU_WAIT && hazard && (hcnt_q != 32'hFFFF_FFFF)) begin
      hcnt_q <= hcnt_q + 32'd1;
    end
  end

  always_comb begin
    SCHEDULE_VALID  = out_q.valid;
    SCHEDULE_LANE   = out_q.lane;
    SCHEDULE_PC     = out_q.f.pc;
    SCHEDULE_OPCODE = out_q.f.opcode;
    SCHEDULE_RD     = out_q.f.rd;
    SCHEDULE_RS1    = out_q.f.rs1;
    SCHEDULE_RS2    = out_q.f.rs2;
    SCHEDULE_CSR    = out_q.f.csr;
    SCHEDULE_IMM    = out_q.f.imm;
    HAZARD_CNT      = hcnt_q;
  end

endmodule

// File: tb/tb_schedule_1.sv
// Bench for schedule_1: directed hazard/flush/freeze sequences plus a random
// lane-priority phase, all checked through an expected-output queue.
module tb_schedule_1;
  import schedule_1_pkg::*;

  localparam int COP_NUMS = 1;
  localparam int PNUMS    = 2;
  localparam int OW       = 113;

  logic                    CLK = 1'b0;
  logic                    RST;
  logic                    FLUSH;
  logic                    MMU_WAIT;
  logic [PNUMS-1:0]        CHECK_ACCEPT;
  logic [32*PNUMS-1:0]     CHECK_PC;
  logic [17*PNUMS-1:0]     CHECK_OPCODE;
  logic [5*PNUMS-1:0]      CHECK_RD;
  logic [5*PNUMS-1:0]      CHECK_RS1;
  logic [5*PNUMS-1:0]      CHECK_RS2;
  logic [12*PNUMS-1:0]     CHECK_CSR;
  logic [32*PNUMS-1:0]     CHECK_IMM;
  logic                    WB_VALID;
  logic [4:0]              WB_RD;
  logic                    STALL;
  logic                    SCHEDULE_VALID;
  logic [3:0]              SCHEDULE_LANE;
  logic [31:0]             SCHEDULE_PC;
  logic [16:0]             SCHEDULE_OPCODE;
  logic [4:0]              SCHEDULE_RD;
  logic [4:0]              SCHEDULE_RS1;
  logic [4:0]              SCHEDULE_RS2;
  logic [11:0]             SCHEDULE_CSR;
  logic [31:0]             SCHEDULE_IMM;
  logic [31:0]             HAZARD_CNT;

  schedule_1 #(.COP_NUMS(COP_NUMS), .PNUMS(PNUMS)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MMU_WAIT(MMU_WAIT),
    .CHECK_ACCEPT(CHECK_ACCEPT), .CHECK_PC(CHECK_PC), .CHECK_OPCODE(CHECK_OPCODE),
    .CHECK_RD(CHECK_RD), .CHECK_RS1(CHECK_RS1), .CHECK_RS2(CHECK_RS2),
    .CHECK_CSR(CHECK_CSR), .CHECK_IMM(CHECK_IMM),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD), .STALL(STALL),
    .SCHEDULE_VALID(SCHEDULE_VALID), .SCHEDULE_LANE(SCHEDULE_LANE),
    .SCHEDULE_PC(SCHEDULE_PC), .SCHEDULE_OPCODE(SCHEDULE_OPCODE),
    .SCHEDULE_RD(SCHEDULE_RD), .SCHEDULE_RS1(SCHEDULE_RS1), .SCHEDULE_RS2(SCHEDULE_RS2),
    .SCHEDULE_CSR(SCHEDULE_CSR), .SCHEDULE_IMM(SCHEDULE_IMM), .HAZARD_CNT(HAZARD_CNT)
  );

  // Clock
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  logic [OW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  wire [OW-1:0] dut_out = {SCHEDULE_VALID, SCHEDULE_LANE, SCHEDULE_PC, SCHEDULE_OPCODE,
                           SCHEDULE_RD, SCHEDULE_RS1, SCHEDULE_RS2, SCHEDULE_CSR, SCHEDULE_IMM};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Driver: one lane's fields; opcode/csr/imm are random payload.
  task automatic set_lane(input int l, input logic [31:0] pc,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    CHECK_PC[l*32 +: 32]     = pc;
    CHECK_OPCODE[l*17 +: 17] = 17'($urandom);
    CHECK_RD[l*5 +: 5]       = rd;
    CHECK_RS1[l*5 +: 5]      = rs1;
    CHECK_RS2[l*5 +: 5]      = rs2;
    CHECK_CSR[l*12 +: 12]    = 12'($urandom);
    CHECK_IMM[l*32 +: 32]    = $urandom;
  endtask

  function automatic logic [OW-1:0] issue_of(input int l);
    return {1'b1, 4'(l), CHECK_PC[l*32 +: 32], CHECK_OPCODE[l*17 +: 17],
            CHECK_RD[l*5 +: 5], CHECK_RS1[l*5 +: 5], CHECK_RS2[l*5 +: 5],
            CHECK_CSR[l*12 +: 12], CHECK_IMM[l*32 +: 32]};
  endfunction

  // One clock: STALL checked mid-cycle, registered output checked after the edge.
  task automatic cycle(input string tag, input logic exp_stall, input logic [OW-1:0] exp_out);
    logic [OW-1:0] e;
    exp_q.push_back(exp_out);
    @(negedge CLK);
    check({tag, ".stall"}, 128'(STALL), 128'(exp_stall));
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check({tag, ".out"}, 128'(dut_out), 128'(e));
  endtask

  initial begin
    logic [OW-1:0] held;
    logic [1:0]    acc;
    RST = 1'b1; FLUSH = 1'b0; MMU_WAIT = 1'b0; CHECK_ACCEPT = '0;
    CHECK_PC = '0; CHECK_OPCODE = '0; CHECK_RD = '0; CHECK_RS1 = '0; CHECK_RS2 = '0;
    CHECK_CSR = '0; CHECK_IMM = '0; WB_VALID = 1'b0; WB_RD = '0;

    cycle("rst0", 1'b0, '0);
    cycle("rst1", 1'b0, '0);
    check("rst_cnt", 128'(HAZARD_CNT), 128'(0));
    RST = 1'b0;

    set_lane(1, 32'h100, 5'd0, 5'd0, 5'd0);
    set_lane(0, 32'h200, 5'd3, 5'd0, 5'd0);
    CHECK_ACCEPT = 2'b11;
    cycle("prio", 1'b0, issue_of(1));
    CHECK_ACCEPT = 2'b01;
    set_lane(0, 32'h204, 5'd0, 5'd0, 5'd0);
    cycle("lane0", 1'b0, issue_of(0));
    CHECK_ACCEPT = 2'b00;
    cycle("bubble", 1'b0, '0);

    // RAW on r5: three hazard cycles, then writeback bypass releases it.
    CHECK_ACCEPT = 2'b01;
    set_lane(0, 32'h300, 5'd5, 5'd1, 5'd2);
    cycle("raw_issue", 1'b0, issue_of(0));
    set_lane(0, 32'h304, 5'd6, 5'd5, 5'd0);
    repeat (3) cycle("raw_stall", 1'b1, '0);
    check("raw_cnt", 128'(HAZARD_CNT), 128'(3));
    WB_VALID = 1'b1; WB_RD = 5'd5;
    cycle("raw_release", 1'b0, issue_of(0));
    WB_VALID = 1'b0;
    check("raw_cnt_hold", 128'(HAZARD_CNT), 128'(3));
    CHECK_ACCEPT = 2'b00; WB_VALID = 1'b1; WB_RD = 5'd6;
    cycle("wb6", 1'b0, '0);
    WB_VALID = 1'b0;

    CHECK_ACCEPT = 2'b01;
    set_lane(0, 32'h400, 5'd0, 5'd0, 5'd0);
    cycle("x0_a", 1'b0, issue_of(0));
    set_lane(0, 32'h404, 5'd0, 5'd0, 5'd0);
    cycle("x0_b", 1'b0, issue_of(0));

    // Set of r7 coinciding with a writeback of r7 must leave r7 busy.
    set_lane(0, 32'h500, 5'd7, 5'd0, 5'd0);
    WB_VALID = 1'b1; WB_RD = 5'd7;
    cycle("race_issue", 1'b0, issue_of(0));
    WB_VALID = 1'b0;
    set_lane(0, 32'h504, 5'd0, 5'd0, 5'd7);
    cycle("race_stall", 1'b1, '0);
    check("race_cnt", 128'(HAZARD_CNT), 128'(4));

    set_lane(1, 32'h600, 5'd5, 5'd0, 5'd0);
    CHECK_ACCEPT = 2'b11;
    held = issue_of(1);
    cycle("cop_issue", 1'b0, held);

    CHECK_ACCEPT = 2'b01; MMU_WAIT = 1'b1;
    cycle("freeze_a", 1'b0, held);
    cycle("freeze_b", 1'b0, held);
    check("freeze_cnt", 128'(HAZARD_CNT), 128'(4));

    // Busy is now r5|r7; flush wins over the freeze and clears it.
    FLUSH = 1'b1;
    cycle("flush", 1'b0, '0);
    FLUSH = 1'b0; MMU_WAIT = 1'b0;
    set_lane(0, 32'h700, 5'd0, 5'd5, 5'd7);
    cycle("post_flush", 1'b0, issue_of(0));
    check("flush_cnt", 128'(HAZARD_CNT), 128'(4));

    set_lane(0, 32'h800, 5'd9, 5'd0, 5'd0);
    cycle("r9_issue", 1'b0, issue_of(0));
    set_lane(0, 32'h804, 5'd0, 5'd9, 5'd0);
    cycle("r9_stall", 1'b1, '0);
    check("r9_cnt", 128'(HAZARD_CNT), 128'(5));
    RST = 1'b1;
    cycle("rst_mid", 1'b1, '0);
    RST = 1'b0;
    check("rst_mid_cnt", 128'(HAZARD_CNT), 128'(0));
    cycle("after_rst", 1'b0, issue_of(0));

    for (int k = 0; k < 24; k++) begin
      acc = 2'($urandom_range(0, 3));
      set_lane(0, $urandom, 5'd0, 5'd0, 5'd0);
      set_lane(1, $urandom, 5'd0, 5'd0, 5'd0);
      CHECK_ACCEPT = acc;
      if (acc[1])      cycle("rand", 1'b0, issue_of(1));
      else if (acc[0]) cycle("rand", 1'b0, issue_of(0));
      else             cycle("rand", 1'b0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
